// File: rtl/programador_ciclo.sv
// ============================================================================
// Module   : programador_ciclo
// Brief    : Wash-program sequencer. It runs a fill, agitate and drain pass
//            for the wash, repeats it for N rinses, then spins once. Fill and
//            drain watchdogs send it to a sticky fault state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module programador_ciclo #(
  parameter int W_TEMPO      = 8,
  parameter int T_LAVAR      = 20,
  parameter int T_ENXAGUE    = 10,
  parameter int T_CENTRIFUGA = 15,
  parameter int T_ENCHER_MAX = 50,
  parameter int T_DRENO_MAX  = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] num_enxagues,
  input  logic       pausa,
  input  logic       porta_fechada,
  input  logic       cheio,
  input  logic       vazio,
  output logic       valvula_agua,
  output logic       valvula_dreno,
  output logic       modo_agitar,
  output logic       modo_girar,
  output logic       trava_porta,
  output logic       ocupado,
  output logic       fim,
  output logic       erro
);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ENCHER      = 3'd1,
    AGITAR      = 3'd2,
    DRENAR      = 3'd3,
    CENTRIFUGAR = 3'd4,
    FIM         = 3'd5,
    ERRO        = 3'd6
  } estado_t;

  // Counter reload values: the counter runs from T-1 down to 0, so a phase
  // or watchdog window spans exactly T unfrozen cycles.
  localparam logic [W_TEMPO-1:0] c_encher_ini = W_TEMPO'(T_ENCHER_MAX - 1);
  localparam logic [W_TEMPO-1:0] c_dreno_ini  = W_TEMPO'(T_DRENO_MAX - 1);
  localparam logic [W_TEMPO-1:0] c_lavar_ini  = W_TEMPO'(T_LAVAR - 1);
  localparam logic [W_TEMPO-1:0] c_enx_ini    = W_TEMPO'(T_ENXAGUE - 1);
  localparam logic [W_TEMPO-1:0] c_centr_ini  = W_TEMPO'(T_CENTRIFUGA - 1);
  localparam logic [W_TEMPO-1:0] c_um         = {{(W_TEMPO-1){1'b0}}, 1'b1};

  estado_t              estado_q, estado_d;
  logic [W_TEMPO-1:0]   cont_q, cont_d;
  logic [1:0]           restantes_q, restantes_d;
  logic                 enxague_q, enxague_d;

  logic                 w_ativo;
  logic                 w_congelado;
  logic                 w_cont_zero;
  logic [W_TEMPO-1:0]   w_cont_dec;

  // Active-phase and freeze decode shared by next-state and output logic
  always_comb begin
    w_ativo     = (estado_q == ENCHER) || (estado_q == AGITAR) ||
                  (estado_q == DRENAR) || (estado_q == CENTRIFUGAR);
    w_congelado = w_ativo && (pausa || !porta_fechada);
    w_cont_zero = (cont_q == '0);
    w_cont_dec  = cont_q - c_um;
  end

  // State, timer and rinse bookkeeping registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cont_q      <= '0;
      restantes_q <= 2'd0;
      enxague_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cont_q      <= cont_d;
      restantes_q <= restantes_d;
      enxague_q   <= enxague_d;
    end
  end

  // Next-state and actuator decode; a frozen active phase holds everything
  always_comb begin
    estado_d      = estado_q;
    cont_d        = cont_q;
    restantes_d   = restantes_q;
    enxague_d     = enxague_q;
    valvula_agua  = 1'b0;
    valvula_dreno = 1'b0;
    modo_agitar   = 1'b0;
    modo_girar    = 1'b0;
    trava_porta   = w_ativo && !pausa;
    ocupado       = (estado_q != OCIOSO) && (estado_q != ERRO);
    fim           = 1'b0;
    erro          = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (iniciar && porta_fechada) begin
          restantes_d = num_enxagues;
          enxague_d   = 1'b0;
          cont_d      = c_encher_ini;
          estado_d    = ENCHER;
        end
      end
      ENCHER: begin
        if (!w_congelado) begin
          valvula_agua = 1'b1;
          // A full drum on the last watchdog cycle still counts as success
          if (cheio) begin
            cont_d   = enxague_q ? c_enx_ini : c_lavar_ini;
            estado_d = AGITAR;
          end else if (w_cont_zero) begin
            estado_d = ERRO;
          end else begin
            cont_d = w_cont_dec;
          end
        end
      end
      AGITAR: begin
        if (!w_congelado) begin
          modo_agitar = 1'b1;
          if (w_cont_zero) begin
            cont_d   = c_dreno_ini;
            estado_d = DRENAR;
          end else begin
            cont_d = w_cont_dec;
          end
        end
      end
      DRENAR: begin
        if (!w_congelado) begin
          valvula_dreno = 1'b1;
          if (vazio) begin
            if (restantes_q != 2'd0) begin
              restantes_d = restantes_q - 2'd1;
              enxague_d   = 1'b1;
              cont_d      = c_encher_ini;
              estado_d    = ENCHER;
            end else begin
              cont_d   = c_centr_ini;
              estado_d = CENTRIFUGAR;
            end
          end else if (w_cont_zero) begin
            estado_d = ERRO;
          end else begin
            cont_d = w_cont_dec;
          end
        end
      end
      CENTRIFUGAR: begin
        if (!w_congelado) begin
          modo_girar    = 1'b1;
          valvula_dreno = 1'b1;
          if (w_cont_zero) begin
            estado_d = FIM;
          end else begin
            cont_d = w_cont_dec;
          end
        end
      end
      FIM: begin
        fim      = 1'b1;
        estado_d = OCIOSO;
      end
      ERRO: begin
        erro = 1'b1;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_programador_ciclo.sv
// ============================================================================
// Module   : tb_programador_ciclo
// Brief    : Scoreboard bench for programador_ciclo. A drum model answers the
//            valves with cheio/vazio; the expected phase lengths of each
//            program are queued at start and checked by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_programador_ciclo;

  localparam int TL = 4;
  localparam int TE = 2;
  localparam int TC = 3;
  localparam int TF = 5;
  localparam int TD = 5;

  localparam int EV_AGIT = 0;
  localparam int EV_SPIN = 1;
  localparam int EV_ERRO = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [1:0] num_enxagues;
  logic       pausa;
  logic       porta_fechada;
  logic       cheio;
  logic       vazio;
  logic       valvula_agua, valvula_dreno, modo_agitar, modo_girar;
  logic       trava_porta, ocupado, fim, erro;

  logic       pause_user, door_user, pz, dz, rnd_pause;
  int         force_fill, force_drain;
  int         n_checks, n_errors;
  ev_t        sb_q[$];

  assign pausa         = pause_user | pz;
  assign porta_fechada = door_user & ~dz;

  programador_ciclo #(
    .W_TEMPO(8), .T_LAVAR(TL), .T_ENXAGUE(TE), .T_CENTRIFUGA(TC),
    .T_ENCHER_MAX(TF), .T_DRENO_MAX(TD)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .num_enxagues(num_enxagues),
    .pausa(pausa), .porta_fechada(porta_fechada), .cheio(cheio), .vazio(vazio),
    .valvula_agua(valvula_agua), .valvula_dreno(valvula_dreno),
    .modo_agitar(modo_agitar), .modo_girar(modo_girar), .trava_porta(trava_porta),
    .ocupado(ocupado), .fim(fim), .erro(erro)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int kind, input int val);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none at %0t", kind, val, $time);
    end else begin
      e = sb_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_length", val, e.val);
    end
  endtask

  // Reference model: a program is one wash agitation, n rinse agitations and one spin
  task automatic push_prog(input int n);
    sb_q.push_back('{EV_AGIT, TL});
    for (int i = 0; i < n; i++) sb_q.push_back('{EV_AGIT, TE});
    sb_q.push_back('{EV_SPIN, TC});
  endtask

  // Drum model: fill and drain take a target number of open-valve cycles
  initial begin
    int fill_cnt, drain_cnt, fill_tgt, drain_tgt;
    fill_cnt = 0; drain_cnt = 0; fill_tgt = 1; drain_tgt = 1;
    cheio = 1'b0; vazio = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        fill_cnt = 0; drain_cnt = 0; cheio = 1'b0; vazio = 1'b1;
      end else if (valvula_agua) begin
        if (fill_cnt == 0) fill_tgt = (force_fill != 0) ? force_fill : int'($urandom_range(1, TF));
        fill_cnt++;
        drain_cnt = 0;
        vazio = 1'b0;
        cheio = (fill_cnt >= fill_tgt);
      end else if (valvula_dreno) begin
        if (drain_cnt == 0) drain_tgt = (force_drain != 0) ? force_drain : int'($urandom_range(1, TD));
        drain_cnt++;
        fill_cnt = 0;
        cheio = 1'b0;
        vazio = (drain_cnt >= drain_tgt);
      end
    end
  end

  // Random pauses and door openings during a running program
  initial begin
    int k;
    pz = 1'b0; dz = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (rnd_pause && ocupado && !fim && ($urandom_range(0, 9) == 0)) begin
        k = int'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) pz = 1'b1;
        else dz = 1'b1;
        repeat (k) @(posedge clock);
        #1;
        pz = 1'b0; dz = 1'b0;
      end
    end
  end

  // Monitor: output rules every cycle, phase lengths against the scoreboard
  initial begin
    int agit, gir, agua, dreno;
    logic erro_seen, fim_prev;
    agit = 0; gir = 0; agua = 0; dreno = 0; erro_seen = 1'b0; fim_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        agit = 0; gir = 0; agua = 0; dreno = 0; erro_seen = 1'b0; fim_prev = 1'b0;
      end else begin
        if (ocupado && !fim && (pausa || !porta_fechada))
          chk("frozen_actuators", {valvula_agua, valvula_dreno, modo_agitar, modo_girar}, 0);
        chk("trava_porta", trava_porta, ocupado && !fim && !pausa);
        if (erro)
          chk("erro_outputs", {valvula_agua, valvula_dreno, modo_agitar, modo_girar,
                               trava_porta, ocupado, fim}, 0);
        if (fim_prev) chk("fim_one_cycle", {fim, ocupado}, 0);
        fim_prev = fim;
        if (valvula_dreno && agit > 0) begin
          sb_pop(EV_AGIT, agit);
          agit = 0;
        end
        if (modo_agitar) agit++;
        if (modo_girar) gir++;
        if (fim) begin
          sb_pop(EV_SPIN, gir);
          gir = 0;
        end
        if (modo_agitar) begin agua = 0; dreno = 0; end
        if (valvula_agua) begin agua++; dreno = 0; end
        if (valvula_dreno && !modo_girar) begin dreno++; agua = 0; end
        if (erro && !erro_seen) begin
          sb_pop(EV_ERRO, agua + dreno);
          erro_seen = 1'b1;
        end
      end
    end
  end

  task automatic start_prog(input logic [1:0] n);
    @(posedge clock);
    #1;
    num_enxagues = n;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    @(negedge clock);
    chk("start_ocupado", ocupado, 1);
    chk("start_valvula_agua", valvula_agua, !(pausa || !porta_fechada));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (ocupado && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk("program_done", ocupado, 0);
    repeat (4) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic wait_for_agitar(input int budget);
    int c = 0;
    while (!modo_agitar && c < budget) begin @(negedge clock); c++; end
    chk("reach_agitar", modo_agitar, 1);
  endtask

  task automatic wait_for_girar(input int budget);
    int c = 0;
    while (!modo_girar && c < budget) begin @(negedge clock); c++; end
    chk("reach_girar", modo_girar, 1);
  endtask

  task automatic wait_for_dreno(input int budget);
    int c = 0;
    while (!valvula_dreno && c < budget) begin @(negedge clock); c++; end
    chk("reach_drenar", valvula_dreno, 1);
  endtask

  task automatic wait_for_erro(input int budget);
    int c = 0;
    while (!erro && c < budget) begin @(negedge clock); c++; end
    chk("reach_erro", erro, 1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("reset_outputs", {valvula_agua, valvula_dreno, modo_agitar, modo_girar,
                          trava_porta, ocupado, fim, erro}, 0);
    sb_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; iniciar = 1'b0; num_enxagues = 2'd0;
    pause_user = 1'b0; door_user = 1'b1; rnd_pause = 1'b0;
    force_fill = 2; force_drain = 2;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_outputs", {valvula_agua, valvula_dreno, modo_agitar, modo_girar,
                          trava_porta, ocupado, fim, erro}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_outputs", {valvula_agua, valvula_dreno, modo_agitar, modo_girar,
                               trava_porta, ocupado, fim, erro}, 0);

    // Start with the door open is refused
    door_user = 1'b0;
    iniciar = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("door_open_no_start", ocupado, 0);
    end
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    door_user = 1'b1;

    // Basic program without rinses
    push_prog(0);
    start_prog(2'd0);
    wait_idle(200);

    // Two rinses; changing the rinse count mid-run must not matter
    push_prog(2);
    start_prog(2'd2);
    num_enxagues = 2'd0;
    wait_idle(300);

    // Pause during agitation and door opened during spin
    push_prog(0);
    start_prog(2'd0);
    wait_for_agitar(50);
    @(posedge clock);
    #1;
    pause_user = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    pause_user = 1'b0;
    wait_for_girar(100);
    @(posedge clock);
    #1;
    door_user = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    door_user = 1'b1;
    wait_idle(200);

    // Drum full on the last watchdog cycle still proceeds
    force_fill = TF;
    force_drain = TD;
    push_prog(1);
    start_prog(2'd1);
    wait_idle(300);

    // Randomized programs with random pauses and sensor timing
    force_fill = 0;
    force_drain = 0;
    rnd_pause = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] n;
      n = 2'($urandom_range(0, 3));
      push_prog(int'(n));
      start_prog(n);
      num_enxagues = 2'($urandom_range(0, 3));
      wait_idle(600);
    end
    rnd_pause = 1'b0;
    repeat (5) @(negedge clock);

    // Fill watchdog: never full, start ignored in ERRO, reset clears
    force_fill = 1000;
    sb_q.push_back('{EV_ERRO, TF});
    start_prog(2'd0);
    wait_for_erro(50);
    @(posedge clock);
    #1;
    iniciar = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    iniciar = 1'b0;
    @(negedge clock);
    chk("erro_sticky", {erro, ocupado}, 2'b10);
    chk("erro_queue_drained", sb_q.size(), 0);
    do_reset();
    @(negedge clock);
    chk("erro_cleared", erro, 0);

    // Drain watchdog
    force_fill = 2;
    force_drain = 1000;
    sb_q.push_back('{EV_AGIT, TL});
    sb_q.push_back('{EV_ERRO, TD});
    start_prog(2'd0);
    wait_for_erro(80);
    @(negedge clock);
    chk("drain_erro_queue_drained", sb_q.size(), 0);
    do_reset();

    // Asynchronous reset in the middle of a drain, then a clean program
    force_drain = 3;
    push_prog(1);
    start_prog(2'd1);
    wait_for_dreno(60);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {valvula_agua, valvula_dreno, modo_agitar, modo_girar,
                                trava_porta, ocupado, fim, erro}, 0);
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    force_drain = 2;
    push_prog(1);
    start_prog(2'd1);
    wait_idle(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/programador_ciclo.md
# programador_ciclo

Wash-program sequencer for the washer. It drives the water valve, drain valve, agitate and spin outputs through a full program: wash, then N rinses, then a final spin. Phase durations come from internal cycle timers. Fill and drain watchdogs catch sensor faults. The block sits between the user panel (start, pause, rinse count) and the machine actuators and level sensors.

## Interface
Parameters:
- W_TEMPO, 8: width of the phase timer and watchdog counter.
- T_LAVAR, 20: wash agitation length in clock cycles.
- T_ENXAGUE, 10: rinse agitation length in cycles.
- T_CENTRIFUGA, 15: final spin length in cycles.
- T_ENCHER_MAX, 50: fill watchdog limit in cycles.
- T_DRENO_MAX, 50: drain watchdog limit in cycles.
- Every T_* value must be in the range 1..2^W_TEMPO-1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  start request; sampled only in OCIOSO.
- num_enxagues  in  2  rinse count 0..3; latched on an accepted start.
- pausa  in  1  freezes the program while high.
- porta_fechada  in  1  door-closed sensor.
- cheio  in  1  drum-full sensor.
- vazio  in  1  drum-empty sensor.
- valvula_agua  out  1  water inlet valve.
- valvula_dreno  out  1  drain valve.
- modo_agitar  out  1  agitate motor mode.
- modo_girar  out  1  spin motor mode.
- trava_porta  out  1  door lock.
- ocupado  out  1  a program is in progress.
- fim  out  1  one-cycle pulse when a program completes.
- erro  out  1  sticky fault indicator.

## Operation
- States: OCIOSO, ENCHER, AGITAR, DRENAR, CENTRIFUGAR, FIM, ERRO.
- Registers:
  - state;
  - W_TEMPO-bit down-counter `cont`, shared by the phase timer and the watchdog;
  - 2-bit `restantes` (rinses left);
  - 1-bit `enxague` (0 = wash pass, 1 = rinse pass).
- Active states: ENCHER, AGITAR, DRENAR, CENTRIFUGAR.
- Freeze condition: active state AND (pausa=1 OR porta_fechada=0).
  - State and `cont` hold.
  - valvula_agua, valvula_dreno, modo_agitar and modo_girar are forced to 0.
- OCIOSO:
  - Start is accepted when iniciar=1 AND porta_fechada=1.
  - On acceptance: restantes<=num_enxagues, enxague<=0, cont<=T_ENCHER_MAX-1, go to ENCHER.
- ENCHER: valvula_agua=1.
  - If cheio=1: go to AGITAR; load cont with T_LAVAR-1 when enxague=0, otherwise T_ENXAGUE-1.
  - Else if cont=0: go to ERRO.
  - Otherwise: decrement cont.
- AGITAR: modo_agitar=1.
  - If cont=0: go to DRENAR with cont<=T_DRENO_MAX-1.
  - Otherwise: decrement cont.
- DRENAR: valvula_dreno=1.
  - If vazio=1 and restantes≠0: restantes--, enxague<=1, cont<=T_ENCHER_MAX-1, go to ENCHER.
  - If vazio=1 and restantes=0: go to CENTRIFUGAR with cont<=T_CENTRIFUGA-1.
  - Else if cont=0: go to ERRO.
  - Otherwise: decrement cont.
- CENTRIFUGAR: modo_girar=1 and valvula_dreno=1.
  - If cont=0: go to FIM.
  - Otherwise: decrement cont.
- FIM: fim=1 for exactly one cycle, then OCIOSO.
- ERRO: all actuator outputs 0, trava_porta=0, erro=1. Exits only on reset; iniciar is ignored.
- trava_porta = active state AND pausa=0.
- ocupado = 1 in every state except OCIOSO and ERRO.

## Timing
- Reset: state=OCIOSO, cont=0, restantes=0, enxague=0. Every output is 0 during and after reset.
- Reset asserted mid-program returns to OCIOSO immediately; all outputs go to 0 asynchronously.
- Outputs are a combinational decode of registered state and the freeze condition; there are no extra pipeline stages.
- Start latency: iniciar sampled high at edge k gives valvula_agua=1 during cycle k+1.
- Phase durations:
  - AGITAR lasts exactly T_LAVAR or T_ENXAGUE unfrozen cycles.
  - CENTRIFUGAR lasts exactly T_CENTRIFUGA unfrozen cycles.
  - Frozen cycles do not count.
- Watchdogs:
  - The fill watchdog trips when cheio stays 0 for T_ENCHER_MAX unfrozen cycles in ENCHER.
  - Drain works the same way, using vazio and T_DRENO_MAX.
- A sensor seen high in the same cycle as cont=0 wins: normal transition, no ERRO.
- Freeze in the same cycle as cont=0 or a sensor high wins: hold, with no transition.
- iniciar outside OCIOSO is ignored. num_enxagues is sampled only at start acceptance.
- Program length with no pauses:
  - ENCHER and DRENAR phases are sensor-determined.
  - Agitation totals T_LAVAR + n*T_ENXAGUE cycles.
  - Then T_CENTRIFUGA cycles of spin, then 1 FIM cycle.

## Test plan
Each scenario uses T_LAVAR=4, T_ENXAGUE=2, T_CENTRIFUGA=3, T_ENCHER_MAX=T_DRENO_MAX=5.
- Basic program with num_enxagues=0 and cheio/vazio asserted 2 cycles after each phase entry → sequence ENCHER, AGITAR (4 cycles), DRENAR, CENTRIFUGAR (3 cycles), then fim high for 1 cycle, then ocupado=0.
- Rinse program with num_enxagues=2 → three fill/agitate/drain passes with agitation lengths 4, 2, 2, then a single spin and a single fim pulse. Changing num_enxagues mid-run has no effect.
- Pause:
  - pausa=1 for 3 cycles mid-AGITAR → modo_agitar=0 and trava_porta=0 while paused; AGITAR still totals 4 active cycles.
  - Door opened mid-CENTRIFUGAR → modo_girar=0 and the spin timer freezes.
- Fill watchdog: cheio held at 0 → erro=1 exactly 5 cycles after ENCHER entry, all actuators 0, iniciar ignored; only reset clears it.
- Boundary: cheio rises on the watchdog's final cycle → AGITAR and no erro. iniciar=1 with porta_fechada=0 → stays in OCIOSO.
- Reset asserted mid-DRENAR → all outputs 0 with no clock edge needed; a new start then runs normally.
